// File: rtl/pipe_seg_adder_if.sv
// rtl/pipe_seg_adder_if.sv - operand/result stream bundle for pipe_seg_adder
// out_ovf exists only when ADD_OVF_EN is defined.
interface pipe_seg_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef ADD_OVF_EN
    logic             out_ovf;
`endif

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout
`ifdef ADD_OVF_EN
        , output out_ovf
`endif
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
`ifdef ADD_OVF_EN
        , input out_ovf
`endif
    );
endinterface

// File: rtl/pipe_seg_adder.sv
// rtl/pipe_seg_adder.sv - segmented pipelined adder/subtractor, one SEG_W ripple per stage
// Optional ADD_OVF_EN adds the registered signed-overflow output out_ovf.
module pipe_seg_adder #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    pipe_seg_adder_if.slave bus
);
    localparam int STAGES = WIDTH / SEG_W;
    localparam int LAST   = STAGES - 1;
    localparam int TOP_SH = WIDTH - SEG_W;

    if ((WIDTH % SEG_W) != 0) begin : g_width_check
        $error("pipe_seg_adder: WIDTH must be a multiple of SEG_W");
    end

    logic             r_v    [STAGES];
    logic             r_c    [STAGES];
    logic [WIDTH-1:0] r_sum  [STAGES];
    logic [WIDTH-1:0] r_a    [STAGES];
    logic [WIDTH-1:0] r_b    [STAGES];

    logic             w_iv   [STAGES];
    logic             w_ic   [STAGES];
    logic [WIDTH-1:0] w_isum [STAGES];
    logic [WIDTH-1:0] w_ia   [STAGES];
    logic [WIDTH-1:0] w_ib   [STAGES];
    logic [SEG_W:0]   w_seg  [STAGES];
    logic [WIDTH-1:0] w_nsum [STAGES];
    logic             w_en;

    assign w_en = ~r_v[LAST] | bus.out_ready;

    assign w_iv[0]   = bus.in_valid;
    assign w_ic[0]   = bus.in_cin;
    assign w_isum[0] = '0;
    assign w_ia[0]   = bus.in_a;
    assign w_ib[0]   = bus.in_b ^ {WIDTH{bus.in_sub}};

    for (genvar k = 1; k < STAGES; k++) begin : g_link
        assign w_iv[k]   = r_v[k-1];
        assign w_ic[k]   = r_c[k-1];
        assign w_isum[k] = r_sum[k-1];
        assign w_ia[k]   = r_a[k-1];
        assign w_ib[k]   = r_b[k-1];
    end

    // Operands shift down so the live segment is always at bit 0; results enter from the top.
    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        assign w_seg[k]  = {1'b0, w_ia[k][SEG_W-1:0]} + {1'b0, w_ib[k][SEG_W-1:0]}
                         + {{SEG_W{1'b0}}, w_ic[k]};
        assign w_nsum[k] = (w_isum[k] >> SEG_W) | (WIDTH'(w_seg[k][SEG_W-1:0]) << TOP_SH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k]   <= 1'b0;
                r_c[k]   <= 1'b0;
                r_sum[k] <= '0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
            end
        end else if (w_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k]   <= w_iv[k];
                r_c[k]   <= w_seg[k][SEG_W];
                r_sum[k] <= w_nsum[k];
                r_a[k]   <= w_ia[k] >> SEG_W;
                r_b[k]   <= w_ib[k] >> SEG_W;
            end
        end
    end

    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_v[LAST];
    assign bus.out_sum   = r_sum[LAST];
    assign bus.out_cout  = r_c[LAST];

`ifdef ADD_OVF_EN
    logic r_ovf;
    logic w_ovf;

    // a^b^s at the MSB recovers the carry into the MSB; xor with carry-out gives overflow.
    assign w_ovf = w_ia[LAST][SEG_W-1] ^ w_ib[LAST][SEG_W-1]
                 ^ w_seg[LAST][SEG_W-1] ^ w_seg[LAST][SEG_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_ovf <= w_ovf;
        end
    end

    assign bus.out_ovf = r_ovf;
`endif
endmodule

// File: tb/tb_pipe_seg_adder.sv
// tb/tb_pipe_seg_adder.sv - scoreboard bench for pipe_seg_adder (32/8 pipeline and 16/16 single stage)
module tb_pipe_seg_adder;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_seg_adder_if #(.WIDTH(32)) bus ();
    pipe_seg_adder_if #(.WIDTH(16)) bus16 ();

    pipe_seg_adder #(.WIDTH(32), .SEG_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pipe_seg_adder #(.WIDTH(16), .SEG_W(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] v_a [8] = '{32'h00000001, 32'h000000FF, 32'h0000FFFF, 32'h80000000,
                             32'h12345678, 32'h00000010, 32'h00000000, 32'hFFFFFFFF};
    logic [31:0] v_b [8] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h80000000,
                             32'h11111111, 32'h00000001, 32'h00000001, 32'hFFFFFFFF};
    logic [31:0] v_s [8] = '{32'h00000002, 32'h00000100, 32'h00010000, 32'h00000000,
                             32'h23456789, 32'h0000000F, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [7:0]  v_cin  = 8'b1110_0000;
    logic [7:0]  v_sub  = 8'b0110_0000;
    logic [7:0]  v_cout = 8'b1010_1000;
    logic [7:0]  v_ovf  = 8'b0000_1000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic sub, input logic ordy,
                               input logic [31:0] es, input logic ec, input logic eo,
                               output logic acc);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_cin    = cin;
        bus.in_sub    = sub;
        bus.out_ready = ordy;
        #1;
        acc = v && bus.in_ready;
        if (acc) sb_q.push_back('{sum: es, cout: ec, ovf: eo});
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, ordy, 32'h0, 1'b0, 1'b0, acc);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, input logic ordy,
                         input logic [31:0] es, input logic ec, input logic eo);
        logic acc;
        int   n;
        n = 0;
        do begin
            drive_cycle(1'b1, a, b, cin, sub, ordy, es, ec, eo, acc);
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: operand a=0x%08h not accepted in %0d cycles", a, n);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            idle(1'b1);
            n++;
        end
        #1;
        check("drain_scoreboard_empty", sb_q.size(), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                check("in_ready_rule", bus.in_ready, (!bus.out_valid || bus.out_ready));
                if (bus.out_valid) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got sum 0x%08h, expected no result", bus.out_sum);
                    end else if (bus.out_ready) begin
                        e = sb_q.pop_front();
                        check("result_sum", bus.out_sum, e.sum);
                        check("result_cout", bus.out_cout, e.cout);
`ifdef ADD_OVF_EN
                        check("result_ovf", bus.out_ovf, e.ovf);
`endif
                    end else begin
                        check("stall_hold_sum", bus.out_sum, sb_q[0].sum);
                        check("stall_hold_cout", bus.out_cout, sb_q[0].cout);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        logic acc;
        int   vi;
        int   p;

        bus.in_valid    = 1'b0;
        bus.in_a        = '0;
        bus.in_b        = '0;
        bus.in_cin      = 1'b0;
        bus.in_sub      = 1'b0;
        bus.out_ready   = 1'b1;
        bus16.in_valid  = 1'b0;
        bus16.in_a      = '0;
        bus16.in_b      = '0;
        bus16.in_cin    = 1'b0;
        bus16.in_sub    = 1'b0;
        bus16.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_sum", bus.out_sum, 0);
        check("reset_out_cout", bus.out_cout, 0);
`ifdef ADD_OVF_EN
        check("reset_out_ovf", bus.out_ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", bus.in_ready, 1);

        issue(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            #1;
            check("latency_not_yet_valid", bus.out_valid, 0);
        end
        idle(1'b1);
        #1;
        check("latency_valid_after_4", bus.out_valid, 1);
        drain();

        issue(32'd5, 32'd7, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        issue(32'd7, 32'd5, 1'b1, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
        drain();

        vi = 0;
        p  = 0;
        while (vi < 8 && p < 200) begin
            drive_cycle(1'b1, v_a[vi], v_b[vi], v_cin[vi], v_sub[vi], (p % 3 == 0),
                        v_s[vi], v_cout[vi], v_ovf[vi], acc);
            if (acc) vi++;
            p++;
        end
        check("stream_all_accepted", vi, 8);
        while (sb_q.size() != 0 && p < 400) begin
            drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, (p % 3 == 0), 32'h0, 1'b0, 1'b0, acc);
            p++;
        end
        drain();

        issue(32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b0, 32'h33333333, 1'b0, 1'b0);
        issue(32'h01010101, 32'h01010101, 1'b0, 1'b0, 1'b0, 32'h02020202, 1'b0, 1'b0);
        issue(32'h00000003, 32'h00000004, 1'b0, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        #1;
        check("pre_reset_out_valid", bus.out_valid, 1);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("async_reset_out_valid", bus.out_valid, 0);
        check("async_reset_out_sum", bus.out_sum, 0);
        check("async_reset_out_cout", bus.out_cout, 0);
        check("async_reset_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'd1, 32'd2, 1'b0, 1'b0, 1'b1, 32'd3, 1'b0, 1'b0);
        drain();
        repeat (6) idle(1'b1);

        issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1);
        issue(32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        drain();

        @(negedge clk);
        check("single_stage_idle_valid", bus16.out_valid, 0);
        bus16.in_valid = 1'b1;
        bus16.in_a     = 16'h1234;
        bus16.in_b     = 16'h0FFF;
        bus16.in_cin   = 1'b1;
        bus16.in_sub   = 1'b0;
        #1;
        check("single_stage_in_ready", bus16.in_ready, 1);
        @(negedge clk);
        bus16.in_valid = 1'b0;
        #1;
        check("single_stage_out_valid", bus16.out_valid, 1);
        check("single_stage_sum", bus16.out_sum, 16'h2234);
        check("single_stage_cout", bus16.out_cout, 0);
`ifdef ADD_OVF_EN
        check("single_stage_ovf", bus16.out_ovf, 0);
`endif
        @(negedge clk);
        #1;
        check("single_stage_no_repeat", bus16.out_valid, 0);

        repeat (3) idle(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
